// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF->ID pipeline stage: default widths, idle
// instruction, FSM state encoding and reset enable.
package if_id_stage_pkg;
  localparam int          IF_ID_ADDR_W   = 32;
  localparam int          IF_ID_INST_W   = 32;
  localparam logic [31:0] IF_ID_NOP_INST = 32'h0000_0000;
  localparam bit          RstEnable      = 1'b1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;
endpackage

// File: rtl/if_id_entry.sv
// One payload slot {pc, inst[, exc]} with synchronous clear and load.
// Optional exc bit is present only when IF_ID_EXC_EN is defined.
module if_id_entry import if_id_stage_pkg::*; #(
  parameter int                ADDR_W   = IF_ID_ADDR_W,
  parameter int                INST_W   = IF_ID_INST_W,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(IF_ID_NOP_INST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [INST_W-1:0] i_inst,
`ifdef IF_ID_EXC_EN
  input  logic              i_exc,
  output logic              o_exc,
`endif
  output logic [ADDR_W-1:0] o_pc,
  output logic [INST_W-1:0] o_inst
);
  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;

  // Clear wins over load so a flush always leaves the slot idle.
  always_ff @(posedge clk) begin
    if ((RstEnable && rst) || i_clear) begin
      r_pc   <= '0;
      r_inst <= NOP_INST;
    end else if (i_load) begin
      r_pc   <= i_pc;
      r_inst <= i_inst;
    end
  end

`ifdef IF_ID_EXC_EN
  logic r_exc;
  always_ff @(posedge clk) begin
    if ((RstEnable && rst) || i_clear) r_exc <= 1'b0;
    else if (i_load)                    r_exc <= i_exc;
  end
  assign o_exc = r_exc;
`endif

  assign o_pc   = r_pc;
  assign o_inst = r_inst;
endmodule

// File: rtl/if_id_stage.sv
// IF->ID stage register with valid/ready handshake, 2-entry skid buffer and
// synchronous flush. Define IF_ID_EXC_EN to add the misaligned-PC flag (o_out_exc).
module if_id_stage import if_id_stage_pkg::*; #(
  parameter int                ADDR_W   = IF_ID_ADDR_W,
  parameter int                INST_W   = IF_ID_INST_W,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(IF_ID_NOP_INST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [ADDR_W-1:0] i_in_pc,
  input  logic [INST_W-1:0] i_in_inst,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ADDR_W-1:0] o_out_pc,
`ifdef IF_ID_EXC_EN
  output logic              o_out_exc,
`endif
  output logic [INST_W-1:0] o_out_inst
);
  state_e r_state;
  logic   r_in_ready, r_out_valid;
  logic   w_in_fire, w_out_fire;
  logic   w_main_load, w_main_clear, w_main_from_skid;
  logic   w_skid_load, w_skid_clear;

  logic [ADDR_W-1:0] w_skid_pc,   w_main_d_pc;
  logic [INST_W-1:0] w_skid_inst, w_main_d_inst, w_in_inst;

  assign w_in_fire  = i_in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & i_out_ready;

`ifdef IF_ID_EXC_EN
  logic w_in_exc, w_skid_exc, w_main_d_exc;
  // Misaligned fetches carry a NOP so the decoder never sees the bad word.
  assign w_in_exc     = |i_in_pc[1:0];
  assign w_in_inst    = w_in_exc ? NOP_INST : i_in_inst;
  assign w_main_d_exc = w_main_from_skid ? w_skid_exc : w_in_exc;
`else
  assign w_in_inst    = i_in_inst;
`endif

  assign w_main_d_pc   = w_main_from_skid ? w_skid_pc   : i_in_pc;
  assign w_main_d_inst = w_main_from_skid ? w_skid_inst : w_in_inst;

  always_comb begin
    w_main_load      = 1'b0;
    w_main_clear     = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    case (r_state)
      ST_EMPTY: w_main_load = w_in_fire;
      ST_ONE: begin
        if (w_in_fire && !w_out_fire) w_skid_load  = 1'b1;
        else if (w_in_fire)           w_main_load  = 1'b1;
        else if (w_out_fire)          w_main_clear = 1'b1;
      end
      ST_TWO: begin
        if (w_out_fire) begin
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
          w_skid_clear     = 1'b1;
        end
      end
      default: ;
    endcase
    if (i_flush) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end
  end

  // State and handshake flags registered together so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if ((RstEnable && rst) || i_flush) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_fire) begin
          r_state     <= ST_ONE;
          r_out_valid <= 1'b1;
        end
        ST_ONE: begin
          if (w_in_fire && !w_out_fire) begin
            r_state    <= ST_TWO;
            r_in_ready <= 1'b0;
          end else if (w_out_fire && !w_in_fire) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_TWO: if (w_out_fire) begin
          r_state    <= ST_ONE;
          r_in_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  if_id_entry #(.ADDR_W(ADDR_W), .INST_W(INST_W), .NOP_INST(NOP_INST)) u_main (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_main_clear),
    .i_load (w_main_load),
    .i_pc   (w_main_d_pc),
    .i_inst (w_main_d_inst),
`ifdef IF_ID_EXC_EN
    .i_exc  (w_main_d_exc),
    .o_exc  (o_out_exc),
`endif
    .o_pc   (o_out_pc),
    .o_inst (o_out_inst)
  );

  if_id_entry #(.ADDR_W(ADDR_W), .INST_W(INST_W), .NOP_INST(NOP_INST)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_skid_clear),
    .i_load (w_skid_load),
    .i_pc   (i_in_pc),
    .i_inst (w_in_inst),
`ifdef IF_ID_EXC_EN
    .i_exc  (w_in_exc),
    .o_exc  (w_skid_exc),
`endif
    .o_pc   (w_skid_pc),
    .o_inst (w_skid_inst)
  );

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed vector table, exc sequence (IF_ID_EXC_EN),
// then random traffic against a queue-based reference model.
module tb_if_id_stage;
  localparam int             AW  = 32;
  localparam int             IW  = 32;
  localparam logic [IW-1:0]  NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid;
  logic [AW-1:0] in_pc = '0, out_pc;
  logic [IW-1:0] in_inst = '0, out_inst;
`ifdef IF_ID_EXC_EN
  logic          out_exc;
`endif

  always #5 clk = ~clk;

  if_id_stage #(.ADDR_W(AW), .INST_W(IW), .NOP_INST(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (flush),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_pc    (in_pc),
    .i_in_inst  (in_inst),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_pc   (out_pc),
`ifdef IF_ID_EXC_EN
    .o_out_exc  (out_exc),
`endif
    .o_out_inst (out_inst)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, flush, iv, ordy;
    logic [31:0] pc, inst;
    logic        ev, er;
    logic [31:0] epc, einst;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, f, iv, input logic [31:0] pc, inst, input logic ordy,
                     input logic ev, er, input logic [31:0] epc, einst);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy;
    v.ev = ev; v.er = er; v.epc = epc; v.einst = einst;
    vecs.push_back(v);
  endtask

  // Reference model: the stage is a 2-deep FIFO whose head is shown on out_*.
  typedef struct { logic [31:0] pc, inst; logic exc; } ent_t;
  ent_t mq[$];

  task automatic model_check(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'(mq.size() > 0));
    chk({tag, "_ready"}, 64'(in_ready),  64'(mq.size() < 2));
    chk({tag, "_pc"},    64'(out_pc),    64'(mq.size() > 0 ? mq[0].pc   : 32'h0));
    chk({tag, "_inst"},  64'(out_inst),  64'(mq.size() > 0 ? mq[0].inst : NOP));
`ifdef IF_ID_EXC_EN
    chk({tag, "_exc"},   64'(out_exc),   64'(mq.size() > 0 ? mq[0].exc  : 1'b0));
`endif
  endtask

  initial begin
    // rst flush iv pc inst ordy | valid ready pc inst
    add(1,0,0, 32'h0,   32'h0,  0,  0,1, 32'h0,   NOP);
    add(1,0,0, 32'h0,   32'h0,  0,  0,1, 32'h0,   NOP);
    add(0,0,1, 32'h100, 32'h11, 1,  1,1, 32'h100, 32'h11);
    add(0,0,1, 32'h104, 32'h22, 1,  1,1, 32'h104, 32'h22);
    add(0,0,1, 32'h108, 32'h33, 1,  1,1, 32'h108, 32'h33);
    add(0,0,0, 32'h0,   32'h0,  1,  0,1, 32'h0,   NOP);
    add(0,0,1, 32'h200, 32'hAA, 0,  1,1, 32'h200, 32'hAA);
    add(0,0,1, 32'h204, 32'hBB, 0,  1,0, 32'h200, 32'hAA);
    add(0,0,1, 32'h208, 32'hCC, 0,  1,0, 32'h200, 32'hAA);
    add(0,0,0, 32'h0,   32'h0,  1,  1,1, 32'h204, 32'hBB);
    add(0,0,0, 32'h0,   32'h0,  1,  0,1, 32'h0,   NOP);
    add(0,0,1, 32'h280, 32'h01, 0,  1,1, 32'h280, 32'h01);
    add(0,0,1, 32'h284, 32'h02, 0,  1,0, 32'h280, 32'h01);
    add(0,1,1, 32'h300, 32'h03, 0,  0,1, 32'h0,   NOP);
    add(0,0,0, 32'h0,   32'h0,  1,  0,1, 32'h0,   NOP);
    add(0,0,1, 32'h400, 32'h04, 0,  1,1, 32'h400, 32'h04);
    add(0,0,1, 32'h404, 32'h05, 0,  1,0, 32'h400, 32'h04);
    add(1,0,1, 32'h408, 32'h06, 1,  0,1, 32'h0,   NOP);
    add(0,0,0, 32'h0,   32'h0,  1,  0,1, 32'h0,   NOP);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; flush = vecs[i].flush; in_valid = vecs[i].iv;
      in_pc = vecs[i].pc; in_inst = vecs[i].inst; out_ready = vecs[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].ev));
      chk($sformatf("vec%0d_ready", i), 64'(in_ready),  64'(vecs[i].er));
      chk($sformatf("vec%0d_pc", i),    64'(out_pc),    64'(vecs[i].epc));
      chk($sformatf("vec%0d_inst", i),  64'(out_inst),  64'(vecs[i].einst));
`ifdef IF_ID_EXC_EN
      chk($sformatf("vec%0d_exc", i),   64'(out_exc),   64'h0);
`endif
    end

`ifdef IF_ID_EXC_EN
    rst = 0; flush = 0; in_valid = 1; in_pc = 32'h102; in_inst = 32'hDEAD; out_ready = 0;
    @(posedge clk); #1;
    chk("exc_misaligned_valid", 64'(out_valid), 64'h1);
    chk("exc_misaligned_pc",    64'(out_pc),    64'h102);
    chk("exc_misaligned_inst",  64'(out_inst),  64'(NOP));
    chk("exc_misaligned_flag",  64'(out_exc),   64'h1);
    in_pc = 32'h104; in_inst = 32'h44; out_ready = 1;
    @(posedge clk); #1;
    chk("exc_aligned_pc",   64'(out_pc),   64'h104);
    chk("exc_aligned_inst", 64'(out_inst), 64'h44);
    chk("exc_aligned_flag", 64'(out_exc),  64'h0);
    in_valid = 0;
    @(posedge clk); #1;
    chk("exc_idle_flag", 64'(out_exc), 64'h0);
`endif

    // Random traffic; the stage is empty here, matching an empty model.
    mq.delete();
    begin
      logic hold = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        logic ifire, ofire;
        rst   = ($urandom_range(0, 199) == 0);
        flush = ($urandom_range(0, 29) == 0);
        out_ready = ($urandom_range(0, 9) < 6);
        if (!hold) begin
          in_valid = ($urandom_range(0, 1) == 1);
          in_pc    = $urandom & ~32'h3;
          if ($urandom_range(0, 3) == 0) in_pc[1:0] = 2'($urandom_range(1, 3));
          in_inst  = $urandom;
        end
        #1;
        model_check("rnd");
        ifire = in_valid && (mq.size() < 2);
        ofire = out_ready && (mq.size() > 0);
        @(posedge clk);
        if (rst || flush) mq.delete();
        else begin
          if (ofire) void'(mq.pop_front());
          if (ifire) begin
            ent_t e;
            e.pc = in_pc;
`ifdef IF_ID_EXC_EN
            e.exc  = (in_pc[1:0] != 2'b00);
            e.inst = e.exc ? NOP : in_inst;
`else
            e.exc  = 1'b0;
            e.inst = in_inst;
`endif
            mq.push_back(e);
          end
        end
        hold = in_valid && !ifire && !rst && !flush;
        #1;
      end
    end
    model_check("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Parametrised IF→ID pipeline stage register: successor to the fixed-width IF/ID latch.
- Adds a valid/ready handshake on both sides, a 2-entry skid buffer and a synchronous flush.
- Because of the skid buffer, in_ready is registered and has no combinational path from out_ready.
- Sits between the fetch unit (upstream) and the decoder (downstream); one instance per fetch lane.

Parameters:
- ADDR_W, 32, PC width in bits.
- INST_W, 32, instruction width in bits.
- NOP_INST, 32'h0000_0000, instruction word presented whenever the stage holds no valid entry; width INST_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all held entries (branch mispredict or exception)
- in_valid  in  1  fetch presents pc/inst
- in_ready  out  1  stage can accept; registered
- in_pc  in  ADDR_W  fetched PC
- in_inst  in  INST_W  fetched instruction
- out_valid  out  1  decoder-side entry valid
- out_ready  in  1  decoder accepts
- out_pc  out  ADDR_W  PC to decode
- out_inst  out  INST_W  instruction to decode
- out_exc  out  1  misaligned-PC flag; present only with IF_ID_EXC_EN

Behaviour:
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Upstream must hold in_pc/in_inst stable while in_valid=1 and in_ready=0.
- Storage:
  - Two entries: main (drives the outputs directly) and skid.
  - All outputs come straight from flops; the stage has no combinational path from input to output.
- Latency: 1 cycle. An entry accepted in cycle N appears on out_* in cycle N+1.
- FSM states: EMPTY, ONE, TWO.
- EMPTY: out_valid=0, in_ready=1.
  - in_fire → main ← input; go to ONE.
- ONE: out_valid=1, in_ready=1.
  - in_fire & out_fire → main ← input; stay in ONE.
  - in_fire only → skid ← input; go to TWO.
  - out_fire only → main ← {pc 0, NOP_INST}; go to EMPTY.
  - Neither → hold.
- TWO: out_valid=0→1 is already held (out_valid=1), in_ready=0.
  - out_fire → main ← skid; go to ONE. The next input is accepted no earlier than the following cycle.
  - No out_fire → hold.
- Idle outputs: while out_valid=0, out_pc=0 and out_inst=NOP_INST. The decoder may therefore decode unconditionally.
- Ordering: strict FIFO. Entries never drop or duplicate, except on flush.
- Flush:
  - Next state is EMPTY; main and skid are cleared to {0, NOP_INST}.
  - Any in_fire in the same cycle is dropped.
  - Next cycle: out_valid=0, in_ready=1.
  - An out_fire in the flush cycle still counts as consumed by the decoder.
- Reset: highest priority, including reset asserted mid-transfer. Values after reset:
  - state = EMPTY
  - in_ready = 1
  - out_valid = 0
  - out_pc = 0
  - out_inst = NOP_INST
  - out_exc = 0
- Priority order: rst > flush > handshake.
- Throughput: with out_ready held at 1, one entry per cycle with no bubbles.

Optional Feature:
- Macro: IF_ID_EXC_EN.
- Defined:
  - On acceptance, in_pc[1:0] != 0 sets a per-entry exc bit, carried through the skid buffer.
  - For such an entry, out_inst is forced to NOP_INST and out_exc=1 while it is in main.
  - out_exc=0 when out_valid=0.
- Undefined:
  - out_exc port and the exc bits are absent.
  - The PC is passed through unchecked.

Decomposition:
- Shared package (precompiled defines):
  - default ADDR_W/INST_W
  - NOP_INST
  - state encoding constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2
  - RstEnable
- One natural sub-module: if_id_entry, the payload register holding {pc, inst[, exc]}. It has load and clear controls and is instantiated twice (main, skid).

Test Plan:
- Reset then idle: rst=1 for 2 cycles → out_valid=0, in_ready=1, out_inst=NOP_INST, out_pc=0.
- Streaming: out_ready=1; in pc=0x100,0x104,0x108 with inst=0x11,0x22,0x33 on consecutive cycles → same triple on out_* one cycle later each, no gaps.
- Backpressure/skid:
  - out_ready=0; send pc 0x200, then 0x204 → in_ready=0 after the second is accepted.
  - Raise out_ready → 0x200, then 0x204 emerge in order.
  - in_ready returns to 1 the cycle after 0x200 drains.
- Flush in state TWO with in_valid=1, pc=0x300 → next cycle out_valid=0, in_ready=1; 0x300 never appears on the output.
- Reset mid-operation: assert rst while in TWO → all reset values next cycle; held entries are lost.
- IF_ID_EXC_EN: in_pc=0x102, inst=0xDEAD → out_exc=1, out_inst=NOP_INST, out_pc=0x102; then pc=0x104 → out_exc=0.
